// File: rtl/ysyx_25040105_exu_pkg.sv
// ysyx_25040105_exu_pkg: op codes, FSM states and byte-lane helpers for the multi-cycle EXU
package ysyx_25040105_exu_pkg;
    localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_SLL = 8'h02, OP_SLT = 8'h03,
                           OP_SLTU = 8'h04, OP_XOR = 8'h05, OP_SRL = 8'h06, OP_SRA = 8'h07,
                           OP_OR = 8'h08, OP_AND = 8'h09, OP_ADDI = 8'h0A, OP_SLTI = 8'h0B,
                           OP_SLTIU = 8'h0C, OP_XORI = 8'h0D, OP_ORI = 8'h0E, OP_ANDI = 8'h0F,
                           OP_SLLI = 8'h10, OP_SRLI = 8'h11, OP_SRAI = 8'h12, OP_LUI = 8'h13,
                           OP_AUIPC = 8'h14, OP_JAL = 8'h15, OP_JALR = 8'h16, OP_BEQ = 8'h17,
                           OP_BNE = 8'h18, OP_BLT = 8'h19, OP_BGE = 8'h1A, OP_BLTU = 8'h1B,
                           OP_BGEU = 8'h1C, OP_LB = 8'h1D, OP_LH = 8'h1E, OP_LW = 8'h1F,
                           OP_LBU = 8'h20, OP_LHU = 8'h21, OP_SB = 8'h22, OP_SH = 8'h23,
                           OP_SW = 8'h24, OP_EBREAK = 8'h25, OP_LWU = 8'h26, OP_MUL = 8'h27,
                           OP_MULH = 8'h28, OP_MULHSU = 8'h29, OP_MULHU = 8'h2A, OP_DIV = 8'h2B,
                           OP_DIVU = 8'h2C, OP_REM = 8'h2D, OP_REMU = 8'h2E;

    typedef enum logic [2:0] {S_IDLE, S_MEM_REQ, S_MEM_RSP, S_MDU, S_DONE} state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mop(input logic [7:0] op);
        return op >= OP_MUL && op <= OP_REMU;
    endfunction

    function automatic logic load_signed(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    // access size: 0 byte, 1 halfword, 2 word
    function automatic logic [1:0] mem_size(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_SB} ? 2'd0 : op inside {OP_LH, OP_LHU, OP_SH} ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] m;
        m = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : 8'h0F;
        return m << off;
    endfunction

    function automatic logic [63:0] lane_extract(input logic [63:0] d, input logic [2:0] off,
                                                 input logic [1:0] sz, input logic sx);
        logic [63:0] s;
        s = d >> {off, 3'b000};
        return sz == 2'd0 ? {{56{sx & s[7]}}, s[7:0]} :
               sz == 2'd1 ? {{48{sx & s[15]}}, s[15:0]} : {{32{sx & s[31]}}, s[31:0]};
    endfunction
endpackage

// File: rtl/ysyx_25040105_mdu.sv
// ysyx_25040105_mdu: iterative RV-M unit; shift-add multiply and restoring divide on magnitudes,
// XLEN iterations with the first one folded into the start cycle.
module ysyx_25040105_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] p_q, p_d, wp, prod, sdiv, smul;
    logic [XLEN-1:0]   d_q, d_d, wd, ua, ub, q, r;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              busy_q, busy_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
    logic              an, bn, wdiv, ge, step;
    logic [XLEN:0]     shd, sum, mh;
    logic [XLEN+1:0]   diff;

    always_comb begin
        an = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) && a[XLEN-1];
        bn = (op == 3'd1 || op == 3'd4 || op == 3'd6) && b[XLEN-1];
        ua = an ? -a : a;
        ub = bn ? -b : b;
        // mul keeps {hi, multiplier}, div keeps {remainder, dividend/quotient}
        wp = start ? {{XLEN{1'b0}}, op[2] ? ua : ub} : p_q;
        wd = start ? (op[2] ? ub : ua) : d_q;
        wdiv = start ? op[2] : op_q[2];
        shd = {wp[2*XLEN-1:XLEN], wp[XLEN-1]};
        diff = {1'b0, shd} - {2'b00, wd};
        ge = !diff[XLEN+1];
        sdiv = {ge ? diff[XLEN-1:0] : shd[XLEN-1:0], wp[XLEN-2:0], ge};
        sum = {1'b0, wp[2*XLEN-1:XLEN]} + {1'b0, wd};
        mh = wp[0] ? sum : {1'b0, wp[2*XLEN-1:XLEN]};
        smul = {mh, wp[XLEN-1:1]};
        done = busy_q && cnt_q == '0;
        step = start || (busy_q && cnt_q != '0);
        p_d = step ? (wdiv ? sdiv : smul) : p_q;
        d_d = wd;
        cnt_d = start ? CW'(XLEN - 1) : step ? cnt_q - 1'b1 : cnt_q;
        busy_d = start || (busy_q && !done);
        op_d = start ? op : op_q;
        qneg_d = start ? an ^ bn : qneg_q;
        rneg_d = start ? an : rneg_q;
        bz_d = start ? b == '0 : bz_q;
        prod = qneg_q ? -p_q : p_q;
        q = p_q[XLEN-1:0];
        r = p_q[2*XLEN-1:XLEN];
        result = op_q == 3'd0 ? prod[XLEN-1:0] :
                 !op_q[2]     ? prod[2*XLEN-1:XLEN] :
                 !op_q[1]     ? (bz_q ? '1 : qneg_q ? -q : q) : (rneg_q ? -r : r);
        busy = busy_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
            op_q <= '0;
            busy_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            bz_q <= 1'b0;
        end else begin
            p_q <= p_d;
            d_q <= d_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            busy_q <= busy_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            bz_q <= bz_d;
        end
    end
endmodule

// File: rtl/ysyx_25040105_exu_mc.sv
// ysyx_25040105_exu_mc: multi-cycle RV32I(+M) execute unit between IDU and WBU with a
// request/response memory port; everything except memory and MDU results is decided at accept.
module ysyx_25040105_exu_mc
    import ysyx_25040105_exu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int HAS_M = 1,
    parameter int OP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_next_pc,
    output logic              out_ebreak,
    output logic              out_illegal,
    output logic              out_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int SW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d, op8, m8;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d, npc_q, npc_d, addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, opb, alu, npc, pc4, tgt, ea, mdu_result;
    logic [NB-1:0]     wmask_q, wmask_d;
    logic [LW-1:0]     off_q, off_d, off;
    logic              ebreak_q, ebreak_d, illegal_q, illegal_d, mis_q, mis_d, wen_q, wen_d;
    logic              ill, ebr, mis, ld, st, accept, mdu_busy, mdu_done;
    logic [SW-1:0]     sh;
    logic [1:0]        sz;
    logic [63:0]       ext;

    // accept-time decode straight from the IDU operands
    always_comb begin
        op8 = in_op[7:0];
        opb = op8 <= OP_AND ? in_rs2 : in_imm;
        sh = opb[SW-1:0];
        pc4 = in_pc + XLEN'(4);
        tgt = in_pc + in_imm;
        ea = in_rs1 + in_imm;
        off = ea[LW-1:0];
        alu = '0;
        npc = pc4;
        ill = 1'b0;
        ebr = 1'b0;
        case (op8)
            OP_ADD, OP_ADDI:   alu = in_rs1 + opb;
            OP_SUB:            alu = in_rs1 - opb;
            OP_SLL, OP_SLLI:   alu = in_rs1 << sh;
            OP_SLT, OP_SLTI:   alu = XLEN'($signed(in_rs1) < $signed(opb));
            OP_SLTU, OP_SLTIU: alu = XLEN'(in_rs1 < opb);
            OP_XOR, OP_XORI:   alu = in_rs1 ^ opb;
            OP_SRL, OP_SRLI:   alu = in_rs1 >> sh;
            OP_SRA, OP_SRAI:   alu = $signed(in_rs1) >>> sh;
            OP_OR, OP_ORI:     alu = in_rs1 | opb;
            OP_AND, OP_ANDI:   alu = in_rs1 & opb;
            OP_LUI:            alu = in_imm;
            OP_AUIPC:          alu = tgt;
            OP_JAL:            begin alu = pc4; npc = tgt; end
            OP_JALR:           begin alu = pc4; npc = ea & ~XLEN'(1); end
            OP_BEQ:            npc = in_rs1 == in_rs2 ? tgt : pc4;
            OP_BNE:            npc = in_rs1 != in_rs2 ? tgt : pc4;
            OP_BLT:            npc = $signed(in_rs1) < $signed(in_rs2) ? tgt : pc4;
            OP_BGE:            npc = $signed(in_rs1) >= $signed(in_rs2) ? tgt : pc4;
            OP_BLTU:           npc = in_rs1 < in_rs2 ? tgt : pc4;
            OP_BGEU:           npc = in_rs1 >= in_rs2 ? tgt : pc4;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW: alu = '0;
            OP_EBREAK:         ebr = 1'b1;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: ill = HAS_M == 0;
            default:           ill = 1'b1;
        endcase
        ld = is_load(op8);
        st = is_store(op8);
        sz = mem_size(op8);
        mis = (ld || st) && ((sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'b00));
    end

    always_comb begin
        in_ready = rst_n && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
        accept = in_valid && in_ready;
        ext = lane_extract(64'(mem_rsp_rdata), 3'(off_q), mem_size(op_q), load_signed(op_q));
        m8 = lane_mask(sz, 3'(off));
        state_d = state_q;
        op_d = op_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        off_d = off_q;
        res_d = res_q;
        npc_d = npc_q;
        ebreak_d = ebreak_q;
        illegal_d = illegal_q;
        mis_d = mis_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wen_d = wen_q;
        case (state_q)
            S_MEM_REQ: state_d = mem_req_ready ? S_MEM_RSP : S_MEM_REQ;
            S_MEM_RSP: begin
                state_d = mem_rsp_valid ? S_DONE : S_MEM_RSP;
                res_d = mem_rsp_valid ? (is_load(op_q) ? XLEN'(ext) : '0) : res_q;
            end
            S_MDU: begin
                state_d = mdu_done ? S_DONE : S_MDU;
                res_d = mdu_done ? mdu_result : res_q;
            end
            S_DONE:    state_d = out_ready ? S_IDLE : S_DONE;
            default:   state_d = state_q;
        endcase
        if (accept) begin
            op_d = op8;
            rs1_d = in_rs1;
            rs2_d = in_rs2;
            off_d = off;
            res_d = alu;
            npc_d = npc;
            ebreak_d = ebr;
            illegal_d = ill;
            mis_d = mis;
            addr_d = {ea[XLEN-1:LW], LW'(0)};
            wdata_d = st ? in_rs2 << {off, 3'b000} : '0;
            wmask_d = st ? m8[NB-1:0] : '0;
            wen_d = st;
            state_d = (ld || st) && !mis ? S_MEM_REQ : is_mop(op8) && !ill ? S_MDU : S_DONE;
        end
    end

    generate
        if (HAS_M != 0) begin : g_mdu
            ysyx_25040105_mdu #(.XLEN(XLEN)) u_mdu (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (state_q == S_MDU && !mdu_busy),
                .op     (3'(op_q - OP_MUL)),
                .a      (rs1_q),
                .b      (rs2_q),
                .busy   (mdu_busy),
                .done   (mdu_done),
                .result (mdu_result)
            );
        end else begin : g_no_mdu
            assign mdu_busy = 1'b0;
            assign mdu_done = 1'b0;
            assign mdu_result = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            off_q <= '0;
            res_q <= '0;
            npc_q <= '0;
            ebreak_q <= 1'b0;
            illegal_q <= 1'b0;
            mis_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            off_q <= off_d;
            res_q <= res_d;
            npc_q <= npc_d;
            ebreak_q <= ebreak_d;
            illegal_q <= illegal_d;
            mis_q <= mis_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q <= wen_d;
        end
    end

    assign out_valid = state_q == S_DONE;
    assign out_result = res_q;
    assign out_next_pc = npc_q;
    assign out_ebreak = ebreak_q;
    assign out_illegal = illegal_q;
    assign out_misalign = mis_q;
    assign mem_req_valid = state_q == S_MEM_REQ;
    assign mem_req_addr = addr_q;
    assign mem_req_wen = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
endmodule

// File: tb/tb_ysyx_25040105_exu_mc.sv
// tb_ysyx_25040105_exu_mc: directed checks of the EXU with hand-computed expectations.
module tb_ysyx_25040105_exu_mc;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic [7:0]  in_op = '0;
    logic [31:0] out_result, out_next_pc, mem_req_addr, mem_req_wdata, mem_rsp_rdata = '0;
    logic        out_ebreak, out_illegal, out_misalign, mem_req_valid, mem_req_ready = 1'b0;
    logic        mem_req_wen, mem_rsp_valid = 1'b0;
    logic [3:0]  mem_req_wmask;
    int          tests = 0, fails = 0, hs = 0, reqc = 0, lat, hs0, reqc0;

    ysyx_25040105_exu_mc #(.XLEN(32), .HAS_M(1), .OP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_next_pc(out_next_pc),
        .out_ebreak(out_ebreak), .out_illegal(out_illegal), .out_misalign(out_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) hs++;
        if (mem_req_valid) reqc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] pc, rs1, rs2, imm);
        in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] pc, rs1, rs2, imm, output int n);
        out_ready = 1'b1;
        issue(op, pc, rs1, rs2, imm);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_in_ready_low", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {out_valid, mem_req_valid, out_ebreak, out_illegal, out_misalign}, 0);
        check("rst_data", {out_result, out_next_pc, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen}, 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 1);

        run_op(8'h0A, 32'h8000_0000, 32'd5, 32'd0, -32'sd3, lat);
        check("addi_lat", lat, 1);
        check("addi_res", out_result, 32'd2);
        check("addi_npc", out_next_pc, 32'h8000_0004);
        drain();
        check("addi_out_drop", out_valid, 0);

        run_op(8'h01, 32'h0, 32'd5, 32'd7, 32'd0, lat);
        check("sub_res", out_result, 32'hFFFF_FFFE);
        drain();
        run_op(8'h12, 32'h0, 32'h8000_0000, 32'd0, 32'd4, lat);
        check("srai_res", out_result, 32'hF800_0000);
        drain();
        run_op(8'h04, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, lat);
        check("sltu_res", out_result, 32'd1);
        drain();
        run_op(8'h03, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, lat);
        check("slt_res", out_result, 32'd1);
        drain();
        run_op(8'h16, 32'h1000, 32'h2001, 32'd0, 32'd4, lat);
        check("jalr_res", out_result, 32'h1004);
        check("jalr_npc", out_next_pc, 32'h2004);
        drain();
        run_op(8'h13, 32'h0, 32'd0, 32'd0, 32'h1234_5000, lat);
        check("lui_res", out_result, 32'h1234_5000);
        drain();
        run_op(8'h25, 32'h40, 32'd0, 32'd0, 32'd0, lat);
        check("ebreak_flag", {out_ebreak, out_illegal, out_misalign}, 3'b100);
        check("ebreak_npc", out_next_pc, 32'h44);
        drain();
        run_op(8'h3F, 32'h0, 32'd0, 32'd0, 32'd0, lat);
        check("illegal_flag", {out_ebreak, out_illegal, lat}, {2'b01, 32'd1});
        drain();

        hs0 = hs;
        issue(8'h22, 32'h0, 32'h8000_0000, 32'h0000_00AB, 32'd3);
        check("sb_req_valid", mem_req_valid, 1);
        check("sb_req_fields", {mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata},
              {32'h8000_0000, 1'b1, 4'b1000, 32'hAB00_0000});
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("sb_req_drop", {mem_req_valid, out_valid}, 0);
        mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("sb_out_after_ack", {out_valid, out_misalign, out_result}, {2'b10, 32'd0});
        check("sb_handshakes", hs - hs0, 1);
        drain();

        reqc0 = reqc;
        run_op(8'h1E, 32'h0, 32'h8000_0000, 32'd0, 32'd3, lat);
        check("lh_mis", {lat, out_misalign, out_result}, {32'd1, 1'b1, 32'd0});
        drain();
        check("lh_no_req", reqc - reqc0, 0);

        hs0 = hs;
        out_ready = 1'b0;
        issue(8'h1D, 32'h0, 32'h8000_0000, 32'd0, 32'd2);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("lb_stall_req", {mem_req_valid, mem_req_addr, mem_req_wen, out_valid},
                  {1'b1, 32'h8000_0000, 2'b00});
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        check("lb_wait_rsp", {out_valid, mem_req_valid}, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0080_0000;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("lb_res", {out_valid, out_result}, {1'b1, 32'hFFFF_FF80});
        check("lb_handshakes", hs - hs0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("lb_backpressure_hold", {out_valid, in_ready, out_result}, {2'b10, 32'hFFFF_FF80});
        drain();

        run_op(8'h2B, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, lat);
        check("div_ovf_lat", lat, 34);
        check("div_ovf_res", out_result, 32'h8000_0000);
        drain();
        run_op(8'h2D, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, lat);
        check("rem_ovf_res", out_result, 32'd0);
        drain();
        run_op(8'h2C, 32'h0, 32'd7, 32'd0, 32'd0, lat);
        check("divu_by0", out_result, 32'hFFFF_FFFF);
        drain();
        run_op(8'h2D, 32'h0, 32'd7, 32'd0, 32'd0, lat);
        check("rem_by0", out_result, 32'd7);
        drain();
        run_op(8'h2A, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, lat);
        check("mulhu_res", out_result, 32'hFFFF_FFFE);
        drain();
        run_op(8'h29, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, lat);
        check("mulhsu_res", out_result, 32'hFFFF_FFFF);
        drain();
        run_op(8'h28, 32'h0, 32'hFFFF_FFFE, 32'd3, 32'd0, lat);
        check("mulh_res", out_result, 32'hFFFF_FFFF);
        drain();
        run_op(8'h27, 32'h0, 32'hFFFF_FFFD, 32'd5, 32'd0, lat);
        check("mul_res", {lat, out_result}, {32'd34, 32'hFFFF_FFF1});
        drain();
        run_op(8'h2B, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0, lat);
        check("div_neg", out_result, 32'hFFFF_FFFD);
        drain();
        run_op(8'h2D, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0, lat);
        check("rem_neg", out_result, 32'hFFFF_FFFF);
        drain();

        run_op(8'h17, 32'h100, 32'd9, 32'd9, 32'h40, lat);
        check("beq_taken_npc", {out_valid, out_next_pc}, {1'b1, 32'h140});
        in_op = 8'h17; in_pc = 32'h200; in_rs1 = 32'd9; in_rs2 = 32'd8; in_imm = 32'h40;
        in_valid = 1'b1;
        #1;
        check("beq_ready_in_done", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("beq_nt_npc", {out_valid, out_next_pc}, {1'b1, 32'h204});
        drain();

        hs0 = hs;
        issue(8'h24, 32'h0, 32'h8000_0010, 32'h1234_5678, 32'd0);
        check("sw_req", {mem_req_valid, mem_req_wmask, mem_req_wdata}, {1'b1, 4'b1111, 32'h1234_5678});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {mem_req_valid, in_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_flags", {out_valid, mem_req_valid, out_ebreak, out_illegal, out_misalign, in_ready}, 6'b000001);
        check("rst_mid_data", {out_result, out_next_pc, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen}, 0);
        check("rst_mid_no_hs", hs - hs0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
